// File: rtl/riscv_processor.sv
// Single-cycle RV32 integer core with a fixed program ROM, a 32x32 register
// file and a word-addressed data RAM. Result exports the ALU output of the
// instruction at the current PC.
module riscv_processor #(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Result
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR, ALU_ZERO
    } alu_op_e;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    // Fixed program; every unlisted word is addi x0,x0,0.
    function automatic logic [31:0] rom_word(input logic [IW-1:0] idx);
        case (32'(idx))
            0:  return enc_r(7'h00, 5'd0,  5'd0,  3'b111, 5'd31);  // and  x31,x0,x0
            1:  return enc_i(12'd1,  5'd0, 3'b000, 5'd1, OP_IMM);
            2:  return enc_i(12'd2,  5'd0, 3'b000, 5'd2, OP_IMM);
            3:  return enc_i(12'd4,  5'd0, 3'b000, 5'd3, OP_IMM);
            4:  return enc_i(12'd5,  5'd0, 3'b000, 5'd4, OP_IMM);
            5:  return enc_i(12'd7,  5'd0, 3'b000, 5'd5, OP_IMM);
            6:  return enc_i(12'd8,  5'd0, 3'b000, 5'd6, OP_IMM);
            7:  return enc_i(12'd11, 5'd0, 3'b000, 5'd7, OP_IMM);
            8:  return enc_r(7'h00, 5'd2,  5'd1,  3'b000, 5'd8);   // add
            9:  return enc_r(7'h20, 5'd3,  5'd2,  3'b000, 5'd9);   // sub
            10: return enc_r(7'h00, 5'd6,  5'd3,  3'b111, 5'd10);  // and
            11: return enc_r(7'h00, 5'd3,  5'd1,  3'b110, 5'd11);  // or
            12: return enc_r(7'h00, 5'd2,  5'd1,  3'b010, 5'd12);  // slt
            13: return enc_r(7'h00, 5'd6,  5'd7,  3'b100, 5'd13);  // nor
            14: return enc_i(12'h4D2, 5'd9, 3'b111, 5'd14, OP_IMM); // andi 1234
            15: return enc_i(12'h8D7, 5'd1, 3'b110, 5'd15, OP_IMM); // ori -1833
            16: return enc_r(7'h00, 5'd1,  5'd15, 3'b010, 5'd16);  // slt
            17: return enc_i(12'h4D2, 5'd1, 3'b100, 5'd17, OP_IMM); // nori 1234
            18: return enc_s(12'd48, 5'd8, 5'd0, 3'b010);           // sw x8,48(x0)
            19: return enc_i(12'd48, 5'd0, 3'b010, 5'd18, OP_LOAD); // lw x18,48(x0)
            default: return enc_i(12'd0, 5'd0, 3'b000, 5'd0, OP_IMM);
        endcase
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] mem_q  [DMEM_DEPTH];

    logic [31:0] inst;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_v, rs2_v, imm, opb, alu_y, mem_rdata, wb_data;
    logic        use_imm, is_store, reg_we, mem_we, mem_to_reg;
    alu_op_e     alu_op;
    logic        unused_bits;

    assign pc_d   = pc_q + 32'd4;
    assign inst   = rom_word(pc_q[IW+1:2]);
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];

    // x0 is hardwired to zero on both read ports.
    assign rs1_v = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_v = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    assign imm = is_store ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
                          : {{20{inst[31]}}, inst[31:20]};
    assign opb = use_imm ? imm : rs2_v;

    // Control decode; anything not recognised falls through as a NOP.
    always_comb begin
        alu_op     = ALU_ZERO;
        use_imm    = 1'b0;
        is_store   = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        case (opcode)
            OP_R, OP_IMM: begin
                use_imm = (opcode == OP_IMM);
                reg_we  = 1'b1;
                case (f3)
                    3'b000: begin
                        if (opcode == OP_IMM || f7 == 7'h00) alu_op = ALU_ADD;
                        else if (f7 == 7'h20)                alu_op = ALU_SUB;
                        else                                 reg_we = 1'b0;
                    end
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    3'b100:  alu_op = ALU_NOR;
                    default: reg_we = 1'b0;
                endcase
            end
            OP_LOAD: if (f3 == 3'b010) begin
                use_imm    = 1'b1;
                alu_op     = ALU_ADD;
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_STORE: if (f3 == 3'b010) begin
                use_imm  = 1'b1;
                is_store = 1'b1;
                alu_op   = ALU_ADD;
                mem_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU; for lw/sw the output is the effective address.
    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD: alu_y = rs1_v + opb;
            ALU_SUB: alu_y = rs1_v - opb;
            ALU_AND: alu_y = rs1_v & opb;
            ALU_OR:  alu_y = rs1_v | opb;
            ALU_SLT: alu_y = {31'd0, $signed(rs1_v) < $signed(opb)};
            ALU_NOR: alu_y = ~(rs1_v | opb);
            default: alu_y = 32'd0;
        endcase
    end

    assign Result    = alu_y;
    assign mem_rdata = mem_q[alu_y[DW+1:2]];
    assign wb_data   = mem_to_reg ? mem_rdata : alu_y;

    // Address bits outside the ROM/RAM index are intentionally ignored.
    assign unused_bits = ^{pc_q[31:IW+2], pc_q[1:0], alu_y[31:DW+2], alu_y[1:0]};

    // Program counter: one instruction per clock, no control flow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= 32'd0;
        else       pc_q <= pc_d;
    end

    // Register file write port; x0 never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (reg_we && rd != 5'd0) begin
            regs_q[rd] <= wb_data;
        end
    end

    // Data RAM synchronous write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= 32'd0;
        end else if (mem_we) begin
            mem_q[alu_y[DW+1:2]] <= rs2_v;
        end
    end
endmodule

// File: tb/tb_riscv_processor.sv
// Bench for riscv_processor: architectural model of the program plus
// hand-computed Result values for each ROM word.
module tb_riscv_processor;
    logic        clk;
    logic        reset;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    riscv_processor dut (.clk(clk), .reset(reset), .Result(Result));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] EXP [21] = '{
        32'h00000000, 32'h00000001, 32'h00000002, 32'h00000004, 32'h00000005,
        32'h00000007, 32'h00000008, 32'h0000000B, 32'h00000003, 32'hFFFFFFFE,
        32'h00000000, 32'h00000005, 32'h00000001, 32'hFFFFFFF4, 32'h000004D2,
        32'hFFFFF8D7, 32'h00000001, 32'hFFFFFB2C, 32'h00000030, 32'h00000030,
        32'h00000000};

    typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_NOR,
                  M_ADDI, M_ANDI, M_ORI, M_SLTI, M_NORI, M_LW, M_SW, M_NOP} mop_e;
    typedef struct {
        mop_e        op;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] imm;
    } minst_t;

    minst_t      prog [32];
    logic [31:0] mregs [32];
    logic [31:0] mram  [64];
    int          mpc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] m_eval(input minst_t in);
        logic [31:0] a, b;
        a = mregs[in.rs1];
        b = (in.op inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_NOR}) ? mregs[in.rs2] : in.imm;
        case (in.op)
            M_ADD, M_ADDI, M_LW, M_SW: return a + b;
            M_SUB:          return a - b;
            M_AND, M_ANDI:  return a & b;
            M_OR,  M_ORI:   return a | b;
            M_SLT, M_SLTI:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            M_NOR, M_NORI:  return ~(a | b);
            default:        return 32'd0;
        endcase
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        for (int i = 0; i < 64; i++) mram[i] = 32'd0;
        mpc = 0;
    endtask

    // Program in mnemonic form.
    initial begin
        for (int i = 0; i < 32; i++) prog[i] = '{M_NOP, 0, 0, 0, 32'd0};
        prog[0]  = '{M_AND,  31, 0,  0,  32'd0};
        prog[1]  = '{M_ADDI, 1,  0,  0,  32'd1};
        prog[2]  = '{M_ADDI, 2,  0,  0,  32'd2};
        prog[3]  = '{M_ADDI, 3,  0,  0,  32'd4};
        prog[4]  = '{M_ADDI, 4,  0,  0,  32'd5};
        prog[5]  = '{M_ADDI, 5,  0,  0,  32'd7};
        prog[6]  = '{M_ADDI, 6,  0,  0,  32'd8};
        prog[7]  = '{M_ADDI, 7,  0,  0,  32'd11};
        prog[8]  = '{M_ADD,  8,  1,  2,  32'd0};
        prog[9]  = '{M_SUB,  9,  2,  3,  32'd0};
        prog[10] = '{M_AND,  10, 3,  6,  32'd0};
        prog[11] = '{M_OR,   11, 1,  3,  32'd0};
        prog[12] = '{M_SLT,  12, 1,  2,  32'd0};
        prog[13] = '{M_NOR,  13, 7,  6,  32'd0};
        prog[14] = '{M_ANDI, 14, 9,  0,  32'd1234};
        prog[15] = '{M_ORI,  15, 1,  0,  -32'sd1833};
        prog[16] = '{M_SLT,  16, 15, 1,  32'd0};
        prog[17] = '{M_NORI, 17, 1,  0,  32'd1234};
        prog[18] = '{M_SW,   0,  0,  8,  32'd48};
        prog[19] = '{M_LW,   18, 0,  0,  32'd48};
        m_clear();
    end

    // Architectural model: reset clears everything, each edge retires one instruction.
    initial forever begin
        logic [31:0] r;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_clear();
        end else begin
            r = m_eval(prog[mpc]);
            case (prog[mpc].op)
                M_SW:    mram[(r >> 2) % 64] = mregs[prog[mpc].rs2];
                M_LW:    if (prog[mpc].rd != 0) mregs[prog[mpc].rd] = mram[(r >> 2) % 64];
                M_NOP:   ;
                default: if (prog[mpc].rd != 0) mregs[prog[mpc].rd] = r;
            endcase
            mpc = (mpc + 1) % 32;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en && !reset) begin
            chk("model_result", Result, m_eval(prog[mpc]));
            chk("model_pc_index", {27'd0, dut.pc_q[6:2]}, 32'(mpc));
        end
    end

    initial begin
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_pc", dut.pc_q, 32'd0);
        chk("reset_result", Result, EXP[0]);
        for (int i = 0; i < 32; i++) chk($sformatf("reset_x%0d", i), dut.regs_q[i], 32'd0);

        // First pass through the program.
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 chk($sformatf("prog_result_%0d", k), Result, EXP[k]);
        end
        chk("ram_word12", dut.mem_q[12], 32'd3);
        chk("x18_loaded", dut.regs_q[18], 32'd3);
        chk("model_x18", mregs[18], 32'd3);
        chk("model_ram12", mram[12], 32'd3);
        chk("x0_zero", dut.regs_q[0], 32'd0);
        chk("x31_zero", dut.regs_q[31], 32'd0);
        chk("x15_ori", dut.regs_q[15], 32'hFFFFF8D7);

        // NOP words must leave the register file alone.
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) chk($sformatf("nop_x%0d", i), dut.regs_q[i], mregs[i]);
        chk("nop_x17", dut.regs_q[17], 32'hFFFFFB2C);

        // Run through index 31 and wrap back to ROM[0].
        repeat (7) @(posedge clk);
        #1;
        chk("wrap_pc_index", {27'd0, dut.pc_q[6:2]}, 32'd0);
        chk("wrap_result", Result, EXP[0]);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 chk($sformatf("wrap_result_%0d", k), Result, EXP[k]);
        end

        // Asynchronous reset between edges, at instruction 10.
        #2 reset = 1'b1;
        #1;
        chk("midrst_pc", dut.pc_q, 32'd0);
        chk("midrst_result", Result, EXP[0]);
        chk("midrst_ram12", dut.mem_q[12], 32'd0);
        for (int i = 1; i < 32; i++) chk($sformatf("midrst_x%0d", i), dut.regs_q[i], 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("restart_result_0", Result, EXP[0]);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 chk($sformatf("restart_result_%0d", k), Result, EXP[k]);
        end
        chk("restart_ram12", dut.mem_q[12], 32'd3);
        chk("restart_x18", dut.regs_q[18], 32'd3);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_processor.md
Name: riscv_processor

Overview:
- Single-cycle RV32 integer core: one instruction fetched, decoded, executed and written back per clock.
- Contains a PC, a built-in instruction ROM with a fixed program, a 32x32 register file, ALU, immediate generator, control decoder and word-addressed data RAM.
- The only output is the ALU result of the instruction at the current PC, exported as `Result` for top-level observation.
- Standalone top level; no external memory or bus.

Parameters:
- IMEM_DEPTH, 32, instruction ROM words, indexed by PC[6:2]; index wraps modulo depth.
- DMEM_DEPTH, 64, data RAM words, indexed by address[7:2]; index wraps modulo depth.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears the PC, register file and data RAM.
- Result  output  32  combinational ALU output of the instruction at the current PC.

Behaviour:
- Reset (asynchronous, also mid-run):
  - PC=0, all registers x0..x31=0, all RAM words=0, immediately, independent of clk.
  - `Result` then reflects ROM[0], which evaluates to 0x00000000.
- Each rising edge without reset:
  - PC <= PC+4.
  - Register write when RegWrite=1 and rd!=0.
  - RAM write when MemWrite=1.
  - Latency is one cycle per instruction; no stalls, no branches or jumps.
- Register file:
  - Two asynchronous read ports; x0 always reads 0.
  - A write is visible to the next instruction.
- Immediates:
  - I-type: sign-extended inst[31:20].
  - S-type: sign-extended {inst[31:25], inst[11:7]}.
- Decoded instructions:
  - R-type (opcode 0110011):
    - funct3 000 / funct7 0000000: add
    - funct3 000 / funct7 0100000: sub
    - funct3 111: and
    - funct3 110: or
    - funct3 010: slt (signed, result 1 or 0)
    - funct3 100: NOR, i.e. ~(rs1|rs2)
  - I-type ALU (opcode 0010011), rs1 op sign-extended imm:
    - funct3 000: addi
    - funct3 111: andi
    - funct3 110: ori
    - funct3 010: slti
    - funct3 100: NORI, i.e. ~(rs1|imm)
  - Load (0000011, funct3 010): lw, rd <= RAM[rs1+imm].
  - Store (0100011, funct3 010): sw, RAM[rs1+imm] <= rs2.
- Result equals ALU output for every instruction. For lw and sw this is the effective address, not the data.
- Arithmetic: 32-bit two's complement; overflow wraps silently.
- Address handling: low two address bits ignored, no misalignment trap.
- Unrecognised opcodes execute as NOP: no register or RAM write, Result=0.
- RAM read is combinational; RAM write is synchronous.
- ROM program:
  - Constant, word index: instruction.
  - All unlisted words are addi x0,x0,0 (Result 0). After the last NOP the PC index wraps and the program re-executes.
  - Program and Result per instruction:
    - 0: and x31,x0,x0 -> 0x00000000
    - 1: addi x1,x0,1 -> 0x00000001
    - 2: addi x2,x0,2 -> 0x00000002
    - 3: addi x3,x0,4 -> 0x00000004
    - 4: addi x4,x0,5 -> 0x00000005
    - 5: addi x5,x0,7 -> 0x00000007
    - 6: addi x6,x0,8 -> 0x00000008
    - 7: addi x7,x0,11 -> 0x0000000B
    - 8: add x8,x1,x2 -> 0x00000003
    - 9: sub x9,x2,x3 -> 0xFFFFFFFE
    - 10: and x10,x3,x6 -> 0x00000000
    - 11: or x11,x1,x3 -> 0x00000005
    - 12: slt x12,x1,x2 -> 0x00000001
    - 13: nor x13,x7,x6 -> 0xFFFFFFF4
    - 14: andi x14,x9,1234 -> 0x000004D2
    - 15: ori x15,x1,-1833 -> 0xFFFFF8D7
    - 16: slt x16,x15,x1 -> 0x00000001
    - 17: nori x17,x1,1234 -> 0xFFFFFB2C
    - 18: sw x8,48(x0) -> 0x00000030
    - 19: lw x18,48(x0) -> 0x00000030

Test Plan:
- Reset while clk is running: assert reset asynchronously between edges -> PC=0 and Result=0x00000000 immediately; all registers read 0.
- Release reset, then 20 rising edges. Sample Result after each edge -> exactly 0x00000001, 0x00000002, 0x00000004, 0x00000005, 0x00000007, 0x00000008, 0x0000000B, 0x00000003, 0xFFFFFFFE, 0x00000000, 0x00000005, 0x00000001, 0xFFFFFFF4, 0x000004D2, 0xFFFFF8D7, 0x00000001, 0xFFFFFB2C, 0x00000030, 0x00000030, then 0x00000000 (NOP). All 20 ROM results must match (counting ROM[0] shown during reset).
- Memory path after instruction 19: RAM word 12 = 0x00000003 and x18 = 0x00000003.
- x0 protection: after instruction 0, x0 reads 0. Further edges through NOP words leave all registers unchanged.
- Reset asserted mid-program at instruction 10 -> PC=0, x1..x31=0, RAM word 12=0; the sequence restarts from the first value.
- Wrap: run to PC index 31 plus one edge -> PC index wraps to 0 and the program sequence repeats from ROM[0].
